// File: rtl/fact_cu.sv
// Moore control unit for the factorial datapath: sequences counter load/decrement,
// product register and output buffer, and rejects operands whose factorial overflows 32 bits.
module fact_cu #(
    parameter int IWIDE = 4,
    parameter int MAX_N = 12
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Go,
    input  logic [IWIDE-1:0] n,
    input  logic             greater,
    output logic             cld,
    output logic             cen,
    output logic             s1,
    output logic             ren,
    output logic             ben,
    output logic             Done,
    output logic             Err,
    output logic             Busy,
    output logic [2:0]       cs
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_MULT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    typedef struct packed {
        logic cld;
        logic cen;
        logic s1;
        logic ren;
        logic ben;
        logic done;
        logic err;
        logic busy;
    } ctrl_t;

    localparam logic [IWIDE-1:0] MAX_N_W = IWIDE'(MAX_N);

    state_t r_state;
    state_t w_state_next;
    ctrl_t  r_ctrl;
    ctrl_t  w_ctrl_next;

    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_next = Go ? ((n > MAX_N_W) ? S_ERR : S_LOAD) : S_IDLE;
            S_LOAD:  w_state_next = S_CHECK;
            S_CHECK: w_state_next = greater ? S_MULT : S_DONE;
            S_MULT:  w_state_next = S_CHECK;
            // Go must fall before a new request is accepted (4-phase handshake)
            S_DONE:  w_state_next = Go ? S_DONE : S_IDLE;
            S_ERR:   w_state_next = Go ? S_ERR : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Strobes for a given state; registered alongside the state so outputs stay glitch-free.
    function automatic ctrl_t decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_LOAD: begin
                c.cld  = 1'b1;
                c.ren  = 1'b1;
                c.busy = 1'b1;
            end
            S_CHECK: c.busy = 1'b1;
            S_MULT: begin
                c.s1   = 1'b1;
                c.ren  = 1'b1;
                c.cen  = 1'b1;
                c.busy = 1'b1;
            end
            S_DONE: begin
                c.ben  = 1'b1;
                c.done = 1'b1;
            end
            S_ERR:   c.err = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    assign w_ctrl_next = decode(w_state_next);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_state_next;
            r_ctrl  <= w_ctrl_next;
        end
    end

    assign cld  = r_ctrl.cld;
    assign cen  = r_ctrl.cen;
    assign s1   = r_ctrl.s1;
    assign ren  = r_ctrl.ren;
    assign ben  = r_ctrl.ben;
    assign Done = r_ctrl.done;
    assign Err  = r_ctrl.err;
    assign Busy = r_ctrl.busy;
    assign cs   = r_state;

endmodule
